// File: rtl/soc_membus_arbiter_if.sv
// Shared-bus bundle between requesting masters, the arbiter and the slave port.
// The arbiter binds to the slave modport; the master modport drives requests and slave responses.
interface soc_membus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    localparam int GW = $clog2(NUM_MASTERS > 1 ? NUM_MASTERS : 2);

    logic [NUM_MASTERS-1:0]    m_req;
    logic [NUM_MASTERS-1:0]    m_write_en;
    logic [32*NUM_MASTERS-1:0] m_addr;
    logic [32*NUM_MASTERS-1:0] m_write_data;
    logic [4*NUM_MASTERS-1:0]  m_byte_en;
    logic [NUM_MASTERS-1:0]    m_valid;
    logic [NUM_MASTERS-1:0]    m_timeout;
    logic [31:0]               m_read_data;

    logic                      s_req;
    logic                      s_write_en;
    logic [31:0]               s_addr;
    logic [31:0]               s_write_data;
    logic [3:0]                s_byte_en;
    logic                      s_valid;
    logic [31:0]               s_read_data;

    logic [GW-1:0]             grant_id;
    logic                      busy;

    modport master (
        output m_req, m_write_en, m_addr, m_write_data, m_byte_en,
        output s_valid, s_read_data,
        input  m_valid, m_timeout, m_read_data,
        input  s_req, s_write_en, s_addr, s_write_data, s_byte_en,
        input  grant_id, busy
    );

    modport slave (
        input  m_req, m_write_en, m_addr, m_write_data, m_byte_en,
        input  s_valid, s_read_data,
        output m_valid, m_timeout, m_read_data,
        output s_req, s_write_en, s_addr, s_write_data, s_byte_en,
        output grant_id, busy
    );
endinterface

// File: rtl/soc_membus_arbiter.sv
// Round-robin arbiter sharing one memory-bus slave port among several masters.
// One transaction in flight, registered slave side, optional watchdog abort.
module soc_membus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                 clk,
    input logic                 res_n,
    soc_membus_arbiter_if.slave bus
);
    localparam int GW    = $clog2(NUM_MASTERS > 1 ? NUM_MASTERS : 2);
    localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];
    localparam logic [GW:0]   NM_W    = NUM_MASTERS[GW:0];
    localparam logic [GW-1:0] LAST_ID = GW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                 state;
    logic [GW-1:0]          rr_ptr;
    logic [CW-1:0]          cnt;
    logic [GW-1:0]          sel;
    logic                   found;
    logic [GW:0]            cand;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic                   wd_fire;

    // First requester at or after rr_ptr, wrapping around the master count.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(i);
            if (cand >= NM_W)
                cand = cand - NM_W;
            if (!found && bus.m_req[cand[GW-1:0]]) begin
                found = 1'b1;
                sel   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        gnt_oh[bus.grant_id] = 1'b1;
    end

    assign wd_fire = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            cnt              <= '0;
            bus.s_req        <= 1'b0;
            bus.s_write_en   <= 1'b0;
            bus.s_addr       <= '0;
            bus.s_write_data <= '0;
            bus.s_byte_en    <= '0;
            bus.m_valid      <= '0;
            bus.m_timeout    <= '0;
            bus.m_read_data  <= '0;
            bus.grant_id     <= '0;
            bus.busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        bus.s_req        <= 1'b1;
                        bus.s_write_en   <= bus.m_write_en[sel];
                        bus.s_addr       <= bus.m_addr[sel*32 +: 32];
                        bus.s_write_data <= bus.m_write_data[sel*32 +: 32];
                        bus.s_byte_en    <= bus.m_byte_en[sel*4 +: 4];
                        bus.grant_id     <= sel;
                        bus.busy         <= 1'b1;
                        cnt              <= '0;
                        state            <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.s_valid) begin
                        bus.s_req       <= 1'b0;
                        bus.s_write_en  <= 1'b0;
                        bus.m_read_data <= bus.s_read_data;
                        bus.m_valid     <= gnt_oh;
                        state           <= RELEASE;
                    end else if (wd_fire) begin
                        bus.s_req       <= 1'b0;
                        bus.s_write_en  <= 1'b0;
                        bus.m_read_data <= '0;
                        bus.m_valid     <= gnt_oh;
                        bus.m_timeout   <= gnt_oh;
                        state           <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    bus.m_valid   <= '0;
                    bus.m_timeout <= '0;
                    bus.busy      <= 1'b0;
                    rr_ptr        <= (bus.grant_id == LAST_ID) ? '0 : bus.grant_id + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
